wb_stage: RTL

Writeback stage of the pipelined RV32I core, directly downstream of the memory stage. It holds the MEM/WB pipeline register and decodes register-write intent from the opcode. It selects the writeback value (ALU result, extended load data, or link address) and drives the register-file write port and the forwarding bus. It also latches a sticky architectural halt and counts retired instructions.

---
 rtl/wb_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB register, rd write, forwarding,
// sticky halt latch and saturating retired-instruction counter.
module wb_stage #(
  parameter int          CNT_WIDTH = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in_wb,
  input  logic                 flush_in_wb,
  input  logic                 halt_in_wb,
  input  logic [31:0]          PC_in_wb,
  input  logic [31:0]          Instr_in_wb,
  input  logic [31:0]          ALUOutput_in_wb,
  input  logic [31:0]          LoadExtended_in_wb,
  output logic                 RegWrEn_out_wb,
  output logic [4:0]           Rd_out_wb,
  output logic [31:0]          RegWData_out_wb,
  output logic                 fwd_valid_out_wb,
  output logic                 halt_out_wb,
  output logic [31:0]          PC_out_wb,
  output logic [CNT_WIDTH-1:0] retired_out_wb
);

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  logic                 r_v;
  logic                 r_halt_q;
  logic                 r_halted;
  logic [31:0]          r_pc;
  logic [31:0]          r_instr;
  logic [31:0]          r_alu;
  logic [31:0]          r_ld;
  logic [CNT_WIDTH-1:0] r_retired;

  logic [6:0]  w_opc;
  logic        w_writes;
  logic        w_is_load;
  logic        w_is_link;
  logic        w_illegal;
  logic        w_halt_now;
  logic        w_halted_nxt;
  logic        w_v_nxt;
  logic        w_retire;
  logic [31:0] w_link;
  logic        w_unused;

  assign w_opc = r_instr[6:0];

  always_comb begin
    w_writes  = 1'b0;
    w_is_load = 1'b0;
    w_is_link = 1'b0;
    w_illegal = 1'b0;
    unique case (w_opc)
      OPCODE_LOAD: begin
        w_writes  = 1'b1;
        w_is_load = 1'b1;
      end
      OPCODE_OP_IMM,
      OPCODE_AUIPC,
      OPCODE_OP,
      OPCODE_LUI:  w_writes = 1'b1;
      OPCODE_JALR,
      OPCODE_JAL: begin
        w_writes  = 1'b1;
        w_is_link = 1'b1;
      end
      OPCODE_STORE,
      OPCODE_BRANCH: w_writes = 1'b0;
      default:       w_illegal = 1'b1;
    endcase
  end

  assign w_halt_now   = r_v & (r_halt_q | w_illegal);
  assign w_halted_nxt = r_halted | w_halt_now;
  // Gate on the next halted value too, so the instruction right
  // behind a halting one is already dropped.
  assign w_v_nxt  = valid_in_wb & ~flush_in_wb & ~w_halted_nxt;
  assign w_retire = r_v & ~w_halt_now;
  assign w_link   = r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v       <= 1'b0;
      r_halt_q  <= 1'b0;
      r_halted  <= 1'b0;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_alu     <= '0;
      r_ld      <= '0;
      r_retired <= '0;
    end else begin
      r_v      <= w_v_nxt;
      r_halt_q <= halt_in_wb;
      r_halted <= w_halted_nxt;
      r_pc     <= PC_in_wb;
      r_instr  <= Instr_in_wb;
      r_alu    <= ALUOutput_in_wb;
      r_ld     <= LoadExtended_in_wb;
      if (w_retire && (r_retired != {CNT_WIDTH{1'b1}}))
        r_retired <= r_retired + 1'b1;
    end
  end

  assign Rd_out_wb        = r_instr[11:7];
  assign RegWrEn_out_wb   = r_v & w_writes & (Rd_out_wb != 5'd0)
                          & ~w_halt_now;
  assign fwd_valid_out_wb = RegWrEn_out_wb;
  assign RegWData_out_wb  = w_is_load ? r_ld
                          : w_is_link ? w_link
                          : r_alu;
  assign halt_out_wb      = w_halted_nxt;
  assign PC_out_wb        = r_pc;
  assign retired_out_wb   = r_retired;

  assign w_unused = ^r_instr[31:12];

endmodule
